ssd_scan_ctrl: RTL and testbench



---
 rtl/ssd_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller: frame-aligned word updates, per-digit DP, 16-level PWM.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.

module ssd_glyph_lane (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // Active-low segments, bit 6 = a ... bit 0 = g
  always_comb begin
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
  end
endmodule

module ssd_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_BITS   = 17
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [4*NUM_DIGITS-1:0] word_in,
  input  logic [NUM_DIGITS-1:0]   dp_mask_in,
  input  logic                    word_valid_in,
  output logic                    word_ready_out,
  input  logic [3:0]              bright_in,
  output logic [7:0]              AN_out,
  output logic [7:0]              CATHODE_out,
  output logic                    frame_out
);
  localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] word;
    logic [NUM_DIGITS-1:0]      dp;
  } disp_t;

  logic [DIV_BITS-1:0] pre_cnt, pre_nxt;
  logic [2:0]          dig_idx, dig_nxt;
  logic                tick, frame_end, accept;
  logic                pend_full, pend_full_nxt;
  disp_t               pend, disp, disp_nxt, word_req;

  logic [NUM_DIGITS-1:0][6:0] glyph, seg;
  logic [6:0] seg_sel;
  logic       dp_sel, gate;
  logic [7:0] an_nxt, cath_nxt;

  assign word_req  = {word_in, dp_mask_in};
  assign tick      = &pre_cnt;
  assign frame_end = tick & (dig_idx == LAST_DIG);
  assign pre_nxt   = pre_cnt + DIV_BITS'(1);

  assign word_ready_out = ~pend_full;
  assign accept         = word_valid_in & ~pend_full;

  always_comb begin
    dig_nxt = dig_idx;
    if (tick) dig_nxt = (dig_idx == LAST_DIG) ? 3'd0 : dig_idx + 3'd1;
  end

  // A word accepted on the frame boundary skips the pending stage entirely.
  always_comb begin
    disp_nxt      = disp;
    pend_full_nxt = pend_full;
    if (frame_end && pend_full) begin
      disp_nxt      = pend;
      pend_full_nxt = 1'b0;
    end else if (frame_end && accept) begin
      disp_nxt = word_req;
    end else if (accept) begin
      pend_full_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      pre_cnt   <= '0;
      dig_idx   <= '0;
      pend      <= '0;
      disp      <= '0;
      pend_full <= 1'b0;
    end else begin
      pre_cnt   <= pre_nxt;
      dig_idx   <= dig_nxt;
      disp      <= disp_nxt;
      pend_full <= pend_full_nxt;
      if (accept && !frame_end) pend <= word_req;
    end
  end

  // Decode from next-state so the registered outputs line up with the counters.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lane
      ssd_glyph_lane u_lane (.nib(disp_nxt.word[gi]), .seg(glyph[gi]));
    end
  endgenerate

`ifdef SSD_LEADING_ZERO_BLANK_EN
  // hi_nz[i]: some nibble at index >= i is nonzero
  logic [NUM_DIGITS:0] hi_nz;
  assign hi_nz[NUM_DIGITS] = 1'b0;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      assign hi_nz[gi] = hi_nz[gi+1] | (|disp_nxt.word[gi]);
      if (gi == 0) begin : g_d0
        assign seg[gi] = glyph[gi];
      end else begin : g_dn
        assign seg[gi] = hi_nz[gi] ? glyph[gi] : 7'b1111111;
      end
    end
  endgenerate
`else
  assign seg = glyph;
`endif

  always_comb begin
    seg_sel = 7'b1111111;
    dp_sel  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_nxt == 3'(i)) begin
        seg_sel = seg[i];
        dp_sel  = disp_nxt.dp[i];
      end
    end
    gate   = pre_nxt[DIV_BITS-1 -: 4] <= bright_in;
    an_nxt = 8'hFF;
    if (gate) an_nxt[dig_nxt] = 1'b0;
    cath_nxt = {~dp_sel, seg_sel};
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      AN_out      <= 8'hFF;
      CATHODE_out <= 8'hFF;
      frame_out   <= 1'b0;
    end else begin
      AN_out      <= an_nxt;
      CATHODE_out <= cath_nxt;
      frame_out   <= frame_end;
    end
  end
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl at NUM_DIGITS=4, DIV_BITS=4 (64-clock frames).
module tb_ssd_scan_ctrl;
  localparam int ND = 4;
  localparam int DB = 4;
`ifdef SSD_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] BLK = 8'hFF;
`else
  localparam logic [7:0] BLK = 8'h81;
`endif

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b1;
  logic [15:0] word_in = '0;
  logic [3:0]  dp_mask_in = '0;
  logic        word_valid_in = 1'b0;
  logic        word_ready_out;
  logic [3:0]  bright_in = 4'd15;
  logic [7:0]  AN_out, CATHODE_out;
  logic        frame_out;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;
  int low_cnt [4];
  int hi_bad;

  ssd_scan_ctrl #(.NUM_DIGITS(ND), .DIV_BITS(DB)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .word_in(word_in), .dp_mask_in(dp_mask_in),
    .word_valid_in(word_valid_in), .word_ready_out(word_ready_out), .bright_in(bright_in),
    .AN_out(AN_out), .CATHODE_out(CATHODE_out), .frame_out(frame_out)
  );

  always #5 clk_in = ~clk_in;

  // Edges since reset release; equals the prescaler's total count.
  always @(posedge clk_in or posedge reset_in)
    if (reset_in) cyc <= 0;
    else          cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [7:0]  an;
    logic [7:0]  cath;
    logic        frame;
    logic        rdy;
    logic [3:0]  bright;
    logic        vld;
    logic [15:0] word;
    logic [3:0]  dp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int c, logic [7:0] an, logic [7:0] cath, logic fr, logic rdy,
                              logic [3:0] br, logic v, logic [15:0] w, logic [3:0] dp);
    vec_t r;
    r.cyc = c; r.an = an; r.cath = cath; r.frame = fr; r.rdy = rdy;
    r.bright = br; r.vld = v; r.word = w; r.dp = dp;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    if (cyc > c) begin
      n_chk++; n_fail++;
      $display("FAIL schedule: at cycle %0d, target %0d already passed", cyc, c);
    end
    while (cyc < c) @(negedge clk_in);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // inputs applied after each check: bright, valid, word, dp
    vecs.push_back(mk(  1, 8'hFE, 8'h81, 0, 1, 15, 0, 16'h0000, 4'h0));
    vecs.push_back(mk( 15, 8'hFE, 8'h81, 0, 1, 15, 0, 16'h0000, 4'h0));
    vecs.push_back(mk( 16, 8'hFD, 8'h81, 0, 1, 15, 0, 16'h0000, 4'h0));
    vecs.push_back(mk( 32, 8'hFB, 8'h81, 0, 1, 15, 0, 16'h0000, 4'h0));
    vecs.push_back(mk( 48, 8'hF7, 8'h81, 0, 1, 15, 0, 16'h0000, 4'h0));
    vecs.push_back(mk( 63, 8'hF7, 8'h81, 0, 1, 15, 0, 16'h0000, 4'h0));
    vecs.push_back(mk( 64, 8'hFE, 8'h81, 1, 1, 15, 0, 16'h0000, 4'h0));
    vecs.push_back(mk( 65, 8'hFE, 8'h81, 0, 1, 15, 0, 16'h0000, 4'h0));
    vecs.push_back(mk( 70, 8'hFE, 8'h81, 0, 1, 15, 1, 16'h12AF, 4'b0100));
    vecs.push_back(mk( 71, 8'hFE, 8'h81, 0, 0, 15, 0, 16'h12AF, 4'b0100));
    vecs.push_back(mk( 80, 8'hFD, 8'h81, 0, 0, 15, 1, 16'h0005, 4'h0));
    vecs.push_back(mk(127, 8'hF7, 8'h81, 0, 0, 15, 1, 16'h0005, 4'h0));
    vecs.push_back(mk(128, 8'hFE, 8'hB8, 1, 1, 15, 1, 16'h0005, 4'h0));
    vecs.push_back(mk(129, 8'hFE, 8'hB8, 0, 0, 15, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(144, 8'hFD, 8'h88, 0, 0, 15, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(160, 8'hFB, 8'h12, 0, 0, 15, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(176, 8'hF7, 8'hCF, 0, 0, 15, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(191, 8'hF7, 8'hCF, 0, 0, 15, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(192, 8'hFE, 8'hA4, 1, 1, 15, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(208, 8'hFD, BLK,   0, 1, 15, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(224, 8'hFB, BLK,   0, 1, 15, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(240, 8'hF7, BLK,   0, 1, 15, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(250, 8'hF7, BLK,   0, 1,  3, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(251, 8'hFF, BLK,   0, 1,  3, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(256, 8'hFE, 8'hA4, 1, 1,  3, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(259, 8'hFE, 8'hA4, 0, 1,  3, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(260, 8'hFF, 8'hA4, 0, 1,  3, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(272, 8'hFD, BLK,   0, 1,  3, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(275, 8'hFD, BLK,   0, 1,  3, 0, 16'h0005, 4'h0));
    vecs.push_back(mk(276, 8'hFF, BLK,   0, 1,  3, 0, 16'h0005, 4'h0));

    // Reset state
    @(negedge clk_in);
    chk("reset an",    {8'h0, AN_out},      16'h00FF);
    chk("reset cath",  {8'h0, CATHODE_out}, 16'h00FF);
    chk("reset frame", {15'h0, frame_out},  16'h0000);
    chk("reset ready", {15'h0, word_ready_out}, 16'h0001);
    @(negedge clk_in);
    reset_in = 1'b0;

    foreach (vecs[i]) begin
      wait_cyc(vecs[i].cyc);
      chk($sformatf("an@%0d", vecs[i].cyc),    {8'h0, AN_out},          {8'h0, vecs[i].an});
      chk($sformatf("cath@%0d", vecs[i].cyc),  {8'h0, CATHODE_out},     {8'h0, vecs[i].cath});
      chk($sformatf("frame@%0d", vecs[i].cyc), {15'h0, frame_out},      {15'h0, vecs[i].frame});
      chk($sformatf("ready@%0d", vecs[i].cyc), {15'h0, word_ready_out}, {15'h0, vecs[i].rdy});
      bright_in     = vecs[i].bright;
      word_valid_in = vecs[i].vld;
      word_in       = vecs[i].word;
      dp_mask_in    = vecs[i].dp;
    end

    // bright_in=3: each anode low for exactly 4 clocks of its 16-clock slot
    wait_cyc(320);
    foreach (low_cnt[d]) low_cnt[d] = 0;
    hi_bad = 0;
    for (int k = 0; k < 64; k++) begin
      for (int d = 0; d < 4; d++) if (!AN_out[d]) low_cnt[d]++;
      if (AN_out[7:4] != 4'hF) hi_bad++;
      @(negedge clk_in);
    end
    for (int d = 0; d < 4; d++)
      chk($sformatf("pwm low clocks digit%0d", d), 16'(low_cnt[d]), 16'd4);
    chk("unused anodes low count", 16'(hi_bad), 16'd0);

    // Mid-frame reset with a word pending
    bright_in     = 4'd15;
    word_valid_in = 1'b1;
    word_in       = 16'h9999;
    dp_mask_in    = 4'hF;
    @(negedge clk_in);
    chk("pending ready", {15'h0, word_ready_out}, 16'h0000);
    word_valid_in = 1'b0;
    wait_cyc(390);
    chk("pre-reset an", {8'h0, AN_out}, 16'h00FE);
    reset_in = 1'b1;
    #1;
    chk("async reset an",    {8'h0, AN_out},          16'h00FF);
    chk("async reset cath",  {8'h0, CATHODE_out},     16'h00FF);
    chk("async reset frame", {15'h0, frame_out},      16'h0000);
    chk("async reset ready", {15'h0, word_ready_out}, 16'h0001);
    @(negedge clk_in);
    reset_in = 1'b0;

    wait_cyc(1);
    chk("rst2 an@1",   {8'h0, AN_out},      16'h00FE);
    chk("rst2 cath@1", {8'h0, CATHODE_out}, 16'h0081);
    wait_cyc(16);
    chk("rst2 an@16",   {8'h0, AN_out},      16'h00FD);
    chk("rst2 cath@16", {8'h0, CATHODE_out}, 16'h0081);
    wait_cyc(63);
    chk("rst2 cath@63", {8'h0, CATHODE_out}, 16'h0081);
    // Accept exactly on the frame_end cycle: word goes straight to display
    word_valid_in = 1'b1;
    word_in       = 16'h0003;
    dp_mask_in    = 4'h0;
    wait_cyc(64);
    chk("bypass cath@64",  {8'h0, CATHODE_out},     16'h0086);
    chk("bypass frame@64", {15'h0, frame_out},      16'h0001);
    chk("bypass ready@64", {15'h0, word_ready_out}, 16'h0001);
    word_valid_in = 1'b0;
    wait_cyc(80);
    chk("bypass cath@80", {8'h0, CATHODE_out}, {8'h0, BLK});
    wait_cyc(128);
    chk("bypass cath@128", {8'h0, CATHODE_out}, 16'h0086);
    chk("bypass ready@128", {15'h0, word_ready_out}, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
